// File: rtl/uart_receiver_if.sv
// uart_receiver_if: groups the receiver's serial line, baud tick, frame
// format controls and host-side FIFO/status signals into one bundle.
// The master side drives the line and reads the FIFO; the slave side is
// the receiver itself.
interface uart_receiver_if;
  logic       ov_baud_rt_i;
  logic       rx_i;
  logic [1:0] data_width_i;
  logic [1:0] stop_bits_number_i;
  logic       rx_fifo_read_i;
  logic [7:0] data_rx_o;
  logic       rx_fifo_empty_o;
  logic       rx_fifo_full_o;
  logic       rx_done_o;
  logic       frame_error_o;
  logic       overrun_error_o;
  logic       config_req_slv_o;

  modport master (
    output ov_baud_rt_i, rx_i, data_width_i, stop_bits_number_i, rx_fifo_read_i,
    input  data_rx_o, rx_fifo_empty_o, rx_fifo_full_o, rx_done_o,
           frame_error_o, overrun_error_o, config_req_slv_o
  );

  modport slave (
    input  ov_baud_rt_i, rx_i, data_width_i, stop_bits_number_i, rx_fifo_read_i,
    output data_rx_o, rx_fifo_empty_o, rx_fifo_full_o, rx_done_o,
           frame_error_o, overrun_error_o, config_req_slv_o
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART deframer feeding a first-word-fall-
// through RX FIFO, with held-low line detection as a configuration request.
// Optional feature macro: UART_RX_ERROR_FLAGS_EN enables the frame_error_o
// and overrun_error_o pulses; without it both outputs are tied low.
module uart_receiver #(
  parameter int RX_FIFO_DEPTH  = 64,
  parameter int CFG_REQ_CYCLES = 1_000_000
) (
  input logic           clk_i,
  input logic           rst_i,
  uart_receiver_if.slave bus
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(CFG_REQ_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  logic [1:0]    sync_q;
  logic          rxs;
  logic          tick;
  logic [LW-1:0] lowCnt_q, lowCnt_d;
  logic          cfgHit;
  state_e        state_q, state_d;
  logic [3:0]    baudCnt_q, baudCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic          stopCnt_q, stopCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          frameDone;
  logic [2:0]    lastBit;
  logic          twoStop;
  logic [7:0]    rxWord;
  logic [7:0]    mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrEn, rdEn;
  logic [7:0]    dataOut_q, dataOut_d;
  logic          empty_q, full_q;
  logic          rxDone_q, cfgReq_q;

  assign rxs     = sync_q[1];
  assign tick    = bus.ov_baud_rt_i;
  assign lastBit = {1'b0, bus.data_width_i} + 3'd4;
  assign twoStop = (bus.stop_bits_number_i == 2'b01);
  assign rxWord  = shift_q >> (2'd3 - bus.data_width_i);

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.rx_i};
  end

  // Count consecutive low cycles; flag the single cycle the threshold is reached.
  always_comb begin
    lowCnt_d = lowCnt_q;
    cfgHit   = 1'b0;
    if (rxs) begin
      lowCnt_d = '0;
    end else if (lowCnt_q != LW'(CFG_REQ_CYCLES)) begin
      lowCnt_d = lowCnt_q + LW'(1);
      cfgHit   = (lowCnt_q == LW'(CFG_REQ_CYCLES - 1));
    end
  end

  // Low-time counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) lowCnt_q <= '0;
    else       lowCnt_q <= lowCnt_d;
  end

  // Deframing FSM next state: start validation, data shifting, stop sampling.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    shift_d   = shift_q;
    frameDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          baudCnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (baudCnt_q == 4'd7) begin
            baudCnt_d = '0;
            if (!rxs) begin
              state_d  = DATA;
              bitCnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            baudCnt_d = baudCnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (baudCnt_q == 4'd15) begin
            shift_d   = {rxs, shift_q[7:1]};
            baudCnt_d = '0;
            if (bitCnt_q == lastBit) begin
              state_d   = STOP;
              bitCnt_d  = '0;
              stopCnt_d = 1'b0;
            end else begin
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end else begin
            baudCnt_d = baudCnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (baudCnt_q == 4'd15) begin
            baudCnt_d = '0;
            if (twoStop && !stopCnt_q) begin
              stopCnt_d = 1'b1;
            end else begin
              frameDone = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            baudCnt_d = baudCnt_q + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cfgHit) begin
      state_d   = BREAK;
      frameDone = 1'b0;
    end
  end

  // FSM and deframing registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      shift_q   <= shift_d;
    end
  end

  assign wrEn = frameDone && !full_q;
  assign rdEn = bus.rx_fifo_read_i && (count_q != '0);

  // FIFO pointer/count update and the next first-word-fall-through head.
  always_comb begin
    wrPtr_d = wrEn ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = rdEn ? rdPtr_q + AW'(1) : rdPtr_q;
    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)                       dataOut_d = '0;
    else if (wrEn && (rdPtr_d == wrPtr_q))   dataOut_d = rxWord;
    else                                     dataOut_d = mem_q[rdPtr_d];
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem_q[wrPtr_q] <= rxWord;
  end

  // FIFO control and registered host-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      dataOut_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      rxDone_q  <= 1'b0;
      cfgReq_q  <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      dataOut_q <= dataOut_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CW'(RX_FIFO_DEPTH));
      rxDone_q  <= frameDone;
      cfgReq_q  <= cfgHit;
    end
  end

  assign bus.data_rx_o        = dataOut_q;
  assign bus.rx_fifo_empty_o  = empty_q;
  assign bus.rx_fifo_full_o   = full_q;
  assign bus.rx_done_o        = rxDone_q;
  assign bus.config_req_slv_o = cfgReq_q;

`ifdef UART_RX_ERROR_FLAGS_EN
  logic stopErr_q;
  logic frameErr_q, overrun_q;

  // Remember a low first stop bit so a two-stop frame reports it at completion.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != STOP)
      stopErr_q <= 1'b0;
    else if (tick && baudCnt_q == 4'd15 && !rxs)
      stopErr_q <= 1'b1;
  end

  // Error pulses aligned with the rx_done_o pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= frameDone && (stopErr_q || !rxs);
      overrun_q  <= frameDone && full_q;
    end
  end

  assign bus.frame_error_o   = frameErr_q;
  assign bus.overrun_error_o = overrun_q;
`else
  assign bus.frame_error_o   = 1'b0;
  assign bus.overrun_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed scenarios for uart_receiver with a small FIFO
// and a short configuration-request threshold.
module tb_uart_receiver;

`ifdef UART_RX_ERROR_FLAGS_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   tickPeriod = 4;
  int   tickDiv = 0;
  int   doneCnt = 0, ferrCnt = 0, ovrCnt = 0, cfgCnt = 0;
  logic [7:0] lastDoneData;
  logic lastDoneEmpty;

  uart_receiver_if bus();

  uart_receiver #(.RX_FIFO_DEPTH(4), .CFG_REQ_CYCLES(200)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Baud tick generator, one tick every tickPeriod clocks.
  always @(negedge clk) begin
    if (tickDiv >= tickPeriod - 1) begin
      bus.ov_baud_rt_i = 1'b1;
      tickDiv = 0;
    end else begin
      bus.ov_baud_rt_i = 1'b0;
      tickDiv++;
    end
  end

  // Pulse monitor; tests compare deltas of these counters.
  always @(negedge clk) begin
    if (bus.rx_done_o === 1'b1) begin
      doneCnt++;
      lastDoneData  = bus.data_rx_o;
      lastDoneEmpty = bus.rx_fifo_empty_o;
    end
    if (bus.frame_error_o === 1'b1)    ferrCnt++;
    if (bus.overrun_error_o === 1'b1)  ovrCnt++;
    if (bus.config_req_slv_o === 1'b1) cfgCnt++;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: time limit expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  task automatic waitTicks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (bus.ov_baud_rt_i === 1'b1) c++;
    end
    #1;
  endtask

  task automatic driveBit(input logic b, input int n);
    bus.rx_i = b;
    waitTicks(n);
  endtask

  task automatic sendFrame(input logic [7:0] d, input int nbits, input int nstop, input bit lastLow);
    driveBit(1'b0, 16);
    for (int i = 0; i < nbits; i++) driveBit(d[i], 16);
    driveBit(1'b1, 16);
    if (nstop == 2) begin
      if (lastLow) driveBit(1'b0, 12);
      else         driveBit(1'b1, 16);
    end
    bus.rx_i = 1'b1;
    waitTicks(24);
  endtask

  task automatic readWord();
    bus.rx_fifo_read_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_fifo_read_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_i = 1'b1;
    bus.rx_fifo_read_i = 1'b0;
    bus.data_width_i = 2'b11;
    bus.stop_bits_number_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.data_rx_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h want 00", bus.data_rx_o); end
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", bus.rx_fifo_empty_o); end
    total++; if (bus.rx_fifo_full_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", bus.rx_fifo_full_o); end
    total++; if (bus.rx_done_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", bus.rx_done_o); end
    total++; if (bus.frame_error_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr: got %b want 0", bus.frame_error_o); end
    total++; if (bus.overrun_error_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovr: got %b want 0", bus.overrun_error_o); end
    total++; if (bus.config_req_slv_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_cfg: got %b want 0", bus.config_req_slv_o); end
    rst = 1'b0;
    waitTicks(4);
  endtask

  task automatic test_8n1();
    int d0, f0, o0;
    tickPeriod = 4;
    bus.data_width_i = 2'b11;
    bus.stop_bits_number_i = 2'b00;
    d0 = doneCnt; f0 = ferrCnt; o0 = ovrCnt;
    sendFrame(8'hA5, 8, 1, 1'b0);
    total++; if (doneCnt - d0 !== 1) begin bad++; $display("[TB] FAIL 8n1_done_pulses: got %0d want 1", doneCnt - d0); end
    total++; if (lastDoneData !== 8'hA5) begin bad++; $display("[TB] FAIL 8n1_data_at_done: got %h want a5", lastDoneData); end
    total++; if (lastDoneEmpty !== 1'b0) begin bad++; $display("[TB] FAIL 8n1_empty_at_done: got %b want 0", lastDoneEmpty); end
    total++; if (ferrCnt - f0 !== 0) begin bad++; $display("[TB] FAIL 8n1_ferr: got %0d want 0", ferrCnt - f0); end
    total++; if (ovrCnt - o0 !== 0) begin bad++; $display("[TB] FAIL 8n1_ovr: got %0d want 0", ovrCnt - o0); end
    total++; if (bus.data_rx_o !== 8'hA5) begin bad++; $display("[TB] FAIL 8n1_data: got %h want a5", bus.data_rx_o); end
    readWord();
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL 8n1_empty_after_read: got %b want 1", bus.rx_fifo_empty_o); end
  endtask

  task automatic test_frame_error();
    int d0, f0;
    tickPeriod = 2;
    bus.data_width_i = 2'b00;
    bus.stop_bits_number_i = 2'b01;
    d0 = doneCnt; f0 = ferrCnt;
    sendFrame(8'h13, 5, 2, 1'b1);
    total++; if (doneCnt - d0 !== 1) begin bad++; $display("[TB] FAIL ferr_done_pulses: got %0d want 1", doneCnt - d0); end
    total++; if (lastDoneData !== 8'h13) begin bad++; $display("[TB] FAIL ferr_data_at_done: got %h want 13", lastDoneData); end
    total++; if (ferrCnt - f0 !== ERR_EN) begin bad++; $display("[TB] FAIL ferr_pulses: got %0d want %0d", ferrCnt - f0, ERR_EN); end
    total++; if (bus.data_rx_o !== 8'h13) begin bad++; $display("[TB] FAIL ferr_data: got %h want 13", bus.data_rx_o); end
    readWord();
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL ferr_empty_after_read: got %b want 1", bus.rx_fifo_empty_o); end
  endtask

  task automatic test_glitch();
    int d0, f0, o0, c0;
    tickPeriod = 2;
    bus.data_width_i = 2'b11;
    bus.stop_bits_number_i = 2'b00;
    d0 = doneCnt; f0 = ferrCnt; o0 = ovrCnt; c0 = cfgCnt;
    driveBit(1'b0, 4);
    driveBit(1'b1, 24);
    total++; if (doneCnt - d0 !== 0) begin bad++; $display("[TB] FAIL glitch_done: got %0d want 0", doneCnt - d0); end
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL glitch_empty: got %b want 1", bus.rx_fifo_empty_o); end
    total++; if (ferrCnt - f0 !== 0) begin bad++; $display("[TB] FAIL glitch_ferr: got %0d want 0", ferrCnt - f0); end
    total++; if (ovrCnt - o0 !== 0) begin bad++; $display("[TB] FAIL glitch_ovr: got %0d want 0", ovrCnt - o0); end
    total++; if (cfgCnt - c0 !== 0) begin bad++; $display("[TB] FAIL glitch_cfg: got %0d want 0", cfgCnt - c0); end
  endtask

  task automatic test_fifo_overrun();
    logic [7:0] words [5];
    int d0, o0;
    words = '{8'h5A, 8'h33, 8'hC6, 8'h69, 8'h77};
    tickPeriod = 2;
    bus.data_width_i = 2'b11;
    bus.stop_bits_number_i = 2'b00;
    d0 = doneCnt; o0 = ovrCnt;
    for (int i = 0; i < 4; i++) sendFrame(words[i], 8, 1, 1'b0);
    total++; if (doneCnt - d0 !== 4) begin bad++; $display("[TB] FAIL fifo_done_pulses: got %0d want 4", doneCnt - d0); end
    total++; if (bus.rx_fifo_full_o !== 1'b1) begin bad++; $display("[TB] FAIL fifo_full: got %b want 1", bus.rx_fifo_full_o); end
    total++; if (bus.data_rx_o !== 8'h5A) begin bad++; $display("[TB] FAIL fifo_head: got %h want 5a", bus.data_rx_o); end
    sendFrame(words[4], 8, 1, 1'b0);
    total++; if (ovrCnt - o0 !== ERR_EN) begin bad++; $display("[TB] FAIL fifo_overrun_pulses: got %0d want %0d", ovrCnt - o0, ERR_EN); end
    total++; if (bus.rx_fifo_full_o !== 1'b1) begin bad++; $display("[TB] FAIL fifo_full_after_drop: got %b want 1", bus.rx_fifo_full_o); end
    total++; if (bus.data_rx_o !== 8'h5A) begin bad++; $display("[TB] FAIL fifo_head_after_drop: got %h want 5a", bus.data_rx_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.data_rx_o !== words[i]) begin bad++; $display("[TB] FAIL fifo_read_%0d: got %h want %h", i, bus.data_rx_o, words[i]); end
      readWord();
      if (i == 0) begin
        total++; if (bus.rx_fifo_full_o !== 1'b0) begin bad++; $display("[TB] FAIL fifo_full_after_read: got %b want 0", bus.rx_fifo_full_o); end
      end
    end
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL fifo_empty_after_drain: got %b want 1", bus.rx_fifo_empty_o); end
  endtask

  task automatic test_config_req();
    int d0, c0, f0;
    tickPeriod = 4;
    bus.data_width_i = 2'b11;
    bus.stop_bits_number_i = 2'b00;
    d0 = doneCnt; c0 = cfgCnt; f0 = ferrCnt;
    driveBit(1'b0, 16);
    driveBit(1'b1, 32);
    bus.rx_i = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    driveBit(1'b1, 40);
    total++; if (cfgCnt - c0 !== 1) begin bad++; $display("[TB] FAIL cfg_pulses: got %0d want 1", cfgCnt - c0); end
    total++; if (doneCnt - d0 !== 0) begin bad++; $display("[TB] FAIL cfg_done: got %0d want 0", doneCnt - d0); end
    total++; if (ferrCnt - f0 !== 0) begin bad++; $display("[TB] FAIL cfg_ferr: got %0d want 0", ferrCnt - f0); end
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL cfg_empty: got %b want 1", bus.rx_fifo_empty_o); end
    tickPeriod = 2;
    d0 = doneCnt;
    sendFrame(8'h96, 8, 1, 1'b0);
    total++; if (doneCnt - d0 !== 1) begin bad++; $display("[TB] FAIL cfg_after_done: got %0d want 1", doneCnt - d0); end
    total++; if (bus.data_rx_o !== 8'h96) begin bad++; $display("[TB] FAIL cfg_after_data: got %h want 96", bus.data_rx_o); end
    readWord();
  endtask

  task automatic test_reset_midframe();
    int d0, f0;
    tickPeriod = 2;
    bus.data_width_i = 2'b11;
    bus.stop_bits_number_i = 2'b00;
    sendFrame(8'h42, 8, 1, 1'b0);
    total++; if (bus.data_rx_o !== 8'h42) begin bad++; $display("[TB] FAIL rstmid_pre_data: got %h want 42", bus.data_rx_o); end
    driveBit(1'b0, 16);
    driveBit(1'b0, 16);
    driveBit(1'b0, 16);
    driveBit(1'b1, 16);
    rst = 1'b1;
    bus.rx_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.data_rx_o !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_data: got %h want 00", bus.data_rx_o); end
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_empty: got %b want 1", bus.rx_fifo_empty_o); end
    total++; if (bus.rx_fifo_full_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_full: got %b want 0", bus.rx_fifo_full_o); end
    total++; if (bus.rx_done_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_done: got %b want 0", bus.rx_done_o); end
    rst = 1'b0;
    waitTicks(24);
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_empty_after: got %b want 1", bus.rx_fifo_empty_o); end
    tickPeriod = 1;
    d0 = doneCnt; f0 = ferrCnt;
    sendFrame(8'h81, 8, 1, 1'b0);
    total++; if (doneCnt - d0 !== 1) begin bad++; $display("[TB] FAIL rstmid_next_done: got %0d want 1", doneCnt - d0); end
    total++; if (bus.data_rx_o !== 8'h81) begin bad++; $display("[TB] FAIL rstmid_next_data: got %h want 81", bus.data_rx_o); end
    total++; if (ferrCnt - f0 !== 0) begin bad++; $display("[TB] FAIL rstmid_next_ferr: got %0d want 0", ferrCnt - f0); end
    readWord();
    total++; if (bus.rx_fifo_empty_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_final_empty: got %b want 1", bus.rx_fifo_empty_o); end
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_i = 1'b1;
    bus.rx_fifo_read_i = 1'b0;
    test_reset();
    test_8n1();
    test_frame_error();
    test_glitch();
    test_fifo_overrun();
    test_config_req();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive stage of the UART controller: the far-end counterpart of the transmitter, consuming its TX line. Samples `rx_i` with the shared 16x oversampling baud tick and deframes start, data and stop bits using the same `data_width_i` / `stop_bits_number_i` encodings as the transmitter. Received words go into an RX FIFO that the host side reads. A held-low line is detected as the configuration request the transmitter emits.

## Interface
- `RX_FIFO_DEPTH`, default 64: RX FIFO depth in words, power of two, at least 4.
- `CFG_REQ_CYCLES`, default 1_000_000: consecutive low clock cycles on the synchronized line that count as a configuration request (10 ms at 100 MHz).
- `clk_i`  in  1: system clock; all logic on rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `ov_baud_rt_i`  in  1: one-cycle 16x oversampling baud tick.
- `rx_i`  in  1: asynchronous serial line; idles high.
- `data_width_i`  in  2: data bits per frame; 00=5, 01=6, 10=7, 11=8.
- `stop_bits_number_i`  in  2: 01 selects 2 stop bits; every other value selects 1.
- `rx_fifo_read_i`  in  1: pops the FIFO head; ignored when empty.
- `data_rx_o`  out  8: FIFO head, first-word-fall-through; right-aligned, unused MSBs zero.
- `rx_fifo_empty_o`  out  1: FIFO empty.
- `rx_fifo_full_o`  out  1: FIFO full.
- `rx_done_o`  out  1: one-cycle pulse per accepted frame.
- `frame_error_o`  out  1: one-cycle pulse when a stop bit is sampled low.
- `overrun_error_o`  out  1: one-cycle pulse when a frame is dropped because the FIFO is full.
- `config_req_slv_o`  out  1: one-cycle pulse when a configuration request is detected.

## Operation
- `rx_i` passes through a 2-flop synchronizer reset to 1. All logic below uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK. Baud counter is 4 bits, bit counter 3 bits, stop counter 1 bit.
- **IDLE:** when `rxs` is 0, go to START and clear the baud counter.
- **START:** on each tick, increment the baud counter. On the tick where the counter is 7 (mid start bit):
  - `rxs` = 0: go to DATA and clear the counter.
  - `rxs` = 1: treat as a glitch and return to IDLE; nothing is stored.
- **DATA:** on the tick where the counter is 15, sample `rxs` into the shift register MSB (LSB-first line order), increment the bit counter and clear the baud counter. After the N-th bit, go to STOP. The word stored is the shift register shifted right by 8−N.
- **STOP:** on the tick where the counter is 15, sample the stop bit.
  - With 2 stop bits, the first sample returns to STOP and the second completes the frame.
  - Any low stop sample raises `frame_error_o` at completion; the word is still stored.
  - On completion, write the FIFO if it is not full, otherwise pulse `overrun_error_o` and drop the word. Then go to IDLE.
- **Configuration request:** a free counter counts consecutive cycles with `rxs` = 0 and clears whenever `rxs` = 1.
  - Reaching `CFG_REQ_CYCLES` pulses `config_req_slv_o` once, aborts any frame in progress without writing, and enters BREAK.
  - BREAK waits for `rxs` = 1, then goes to IDLE.
- **FIFO:**
  - A write when full is rejected, even if a read occurs in the same cycle.
  - Simultaneous read and write when not full: the count is unchanged.
  - Pointers wrap modulo `RX_FIFO_DEPTH`.
- **Reset:** FSM to IDLE; all counters zero; FIFO emptied. Output values:
  - `data_rx_o` = 0.
  - `rx_fifo_empty_o` = 1, `rx_fifo_full_o` = 0.
  - All pulse outputs 0.
  - A frame in flight at reset is discarded.

## Timing
- Synchronizer latency: 2 cycles from `rx_i` to `rxs`.
- All outputs are registered.
- The completing stop-bit tick is cycle T. In cycle T+1:
  - `rx_done_o` pulses.
  - For an accepted frame, the FIFO holds the word, `rx_fifo_empty_o` falls if the FIFO was empty, and `data_rx_o` shows the word.
  - `frame_error_o` / `overrun_error_o` pulse if applicable.
- After an `rx_fifo_read_i` cycle, `data_rx_o` updates on the next cycle.
- `config_req_slv_o` pulses in the cycle after the low counter reaches `CFG_REQ_CYCLES`.
- A frame spans (1 + N + stop) × 16 ticks, with the start bit validated at tick 8.

## Configuration
- `UART_RX_ERROR_FLAGS_EN`:
  - **Defined:** `frame_error_o` and `overrun_error_o` behave as specified.
  - **Undefined:** both outputs are tied to 0 and their registers are removed. Receive behaviour is otherwise unchanged: framing-error words are still stored and overrun words are still dropped.

## Test plan
- 8N1 frame of 0xA5 at 1 tick per 4 clocks → `data_rx_o` = 0xA5, `rx_done_o` one pulse, empty deasserted in cycle T+1, no error.
- 5-bit, 2-stop frame carrying 0x13 with the second stop bit low → `data_rx_o` = 0x13, `frame_error_o` pulse, `rx_done_o` pulse.
- Start pulse of 4 ticks then line high → FSM returns to IDLE, FIFO stays empty, no pulses.
- `RX_FIFO_DEPTH` = 4: send 5 frames with no reads → first 4 stored in order, `rx_fifo_full_o` = 1, fifth frame gives an `overrun_error_o` pulse; then 4 reads drain 4 words and empty = 1.
- `CFG_REQ_CYCLES` = 200: hold `rx_i` low for 300 cycles mid-frame → exactly one `config_req_slv_o` pulse, no FIFO write, IDLE after the line returns high.
- Assert `rst_i` during DATA of frame 0x3C → outputs at reset values, next full frame 0x81 received correctly.
